// File: rtl/cc_frame_scheduler.sv
// Frame sequencer for the ColorChord output chain: decimated DFT read pulses trigger one
// NoteFinder -> LinearVisualizer -> LEDDriver2 pass, with per-stage watchdogs and drop counting.
module cc_frame_scheduler #(
  parameter int DECIM       = 1,
  parameter int START_DELAY = 4,
  parameter int TIMEOUT_W   = 24,
  parameter int DROP_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              sample_read_i,
  input  logic              nf_finished_i,
  input  logic              lv_valid_i,
  input  logic              led_done_i,
  output logic              nf_start_o,
  output logic              lv_start_o,
  output logic              led_start_o,
  output logic              busy_o,
  output logic [2:0]        stage_o,
  output logic              timeout_err_o,
  output logic [DROP_W-1:0] drop_count_o,
  output logic [DROP_W-1:0] frame_count_o
);
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DEC_W-1:0]     DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [DLY_W-1:0]     DLY_LAST = DLY_W'(START_DELAY - 1);
  // Timeout is taken on the edge where the watchdog becomes all-ones.
  localparam logic [TIMEOUT_W-1:0] WD_LAST  = {TIMEOUT_W{1'b1}} - 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_NF    = 3'd2,
    S_LV    = 3'd3,
    S_LED   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [DEC_W-1:0]     dec_q, dec_d;
  logic [DLY_W-1:0]     dly_q, dly_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 nf_q, nf_d, lv_q, lv_d, led_q, led_d;
  logic                 tmo_q, tmo_d;
  logic [DROP_W-1:0]    drop_q, drop_d, frame_q, frame_d;
  logic                 trig, wd_hit;

  always_comb begin
    trig    = enable_i && sample_read_i && (dec_q == DEC_LAST);
    wd_hit  = (wdog_q == WD_LAST);
    dec_d   = dec_q;
    state_d = state_q;
    dly_d   = dly_q;
    wdog_d  = wdog_q;
    nf_d    = 1'b0;
    lv_d    = 1'b0;
    led_d   = 1'b0;
    tmo_d   = tmo_q;
    drop_d  = drop_q;
    frame_d = frame_q;

    if (enable_i && sample_read_i)
      dec_d = (dec_q == DEC_LAST) ? '0 : dec_q + 1'b1;
    // Only a registered IDLE accepts; anything else is a drop.
    if (trig && state_q != S_IDLE && drop_q != {DROP_W{1'b1}})
      drop_d = drop_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_DELAY;
          dly_d   = '0;
        end
      end
      S_DELAY: begin
        if (dly_q == DLY_LAST) begin
          state_d = S_NF;
          nf_d    = 1'b1;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      S_NF: begin
        wdog_d = wdog_q + 1'b1;
        if (nf_finished_i) begin
          state_d = S_LV;
          lv_d    = 1'b1;
        end else if (wd_hit) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end
      end
      S_LV: begin
        wdog_d = wdog_q + 1'b1;
        if (lv_valid_i) begin
          state_d = S_LED;
          led_d   = 1'b1;
        end else if (wd_hit) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end
      end
      S_LED: begin
        wdog_d = wdog_q + 1'b1;
        if (led_done_i) begin
          state_d = S_IDLE;
          frame_d = frame_q + 1'b1;
        end else if (wd_hit) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)
      wdog_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dec_q   <= '0;
      dly_q   <= '0;
      wdog_q  <= '0;
      nf_q    <= 1'b0;
      lv_q    <= 1'b0;
      led_q   <= 1'b0;
      tmo_q   <= 1'b0;
      drop_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      dly_q   <= dly_d;
      wdog_q  <= wdog_d;
      nf_q    <= nf_d;
      lv_q    <= lv_d;
      led_q   <= led_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
      frame_q <= frame_d;
    end
  end

  assign nf_start_o    = nf_q;
  assign lv_start_o    = lv_q;
  assign led_start_o   = led_q;
  assign busy_o        = (state_q != S_IDLE);
  assign stage_o       = state_q;
  assign timeout_err_o = tmo_q;
  assign drop_count_o  = drop_q;
  assign frame_count_o = frame_q;
endmodule
